// File: rtl/program_sequencer_pkg.sv
// program_sequencer_pkg
// Shared definitions for the fetch-stage program sequencer: default address
// width and reset vector, the control-flow source encoding used by the PC
// mux, and the width helper for the return-stack occupancy count.
package program_sequencer_pkg;

    localparam int ADDR_W_DEF    = 13;
    localparam int RESET_VEC_DEF = 0;

    // Next-PC source, listed lowest to highest priority.
    typedef enum logic [2:0] {
        SEQ    = 3'd0,
        HOLD   = 3'd1,
        BRANCH = 3'd2,
        JUMP   = 3'd3,
        CALL   = 3'd4,
        RET    = 3'd5
    } flow_e;

    // Count must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// program_sequencer_if
// Groups the sequencer's request inputs and status outputs.
//   master : control unit side (drives requests, observes PC and stack status)
//   slave  : sequencer side
interface program_sequencer_if
    import program_sequencer_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int OFS_W     = 8,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = cnt_w(RAS_DEPTH);

    logic              start;
    logic              stall;
    logic              hlt;
    logic              jump_en;
    logic [ADDR_W-1:0] target_addr;
    logic              branch_en;
    logic [OFS_W-1:0]  branch_ofs;
    logic              call_en;
    logic              ret_en;
    logic [ADDR_W-1:0] instr_mem_addr;
    logic [CW-1:0]     ras_count;
    logic              ras_full;
    logic              ras_empty;
    logic              ras_ovf;
    logic              ras_udf;

    modport master (
        output start, stall, hlt, jump_en, target_addr, branch_en, branch_ofs,
               call_en, ret_en,
        input  instr_mem_addr, ras_count, ras_full, ras_empty, ras_ovf, ras_udf
    );

    modport slave (
        input  start, stall, hlt, jump_en, target_addr, branch_en, branch_ofs,
               call_en, ret_en,
        output instr_mem_addr, ras_count, ras_full, ras_empty, ras_ovf, ras_udf
    );

endinterface

// File: rtl/program_sequencer_pc_return_stack.sv
// pc_return_stack
// LIFO of return addresses for call/return.
//   clk, reset      : clock, async active-high reset (count -> 0)
//   clear           : synchronous flush (count -> 0), wins over push/pop
//   push, push_data : store push_data on top; ignored when full
//   pop             : discard top entry; ignored when empty
//   top_data        : current top entry (don't-care when empty)
//   count/full/empty: occupancy; full/empty decoded from the count register
module pc_return_stack
    import program_sequencer_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int RAS_DEPTH = 4,
    localparam int CW       = cnt_w(RAS_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     top_cnt;
    logic              do_push, do_pop;

    assign full    = (count_q == CW'(RAS_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear && !push;

    // Index wraps harmlessly when empty; top_data is unused then.
    assign top_cnt  = count_q - CW'(1);
    assign top_data = mem_q[top_cnt[PW-1:0]];

    always_comb begin
        count_d = count_q;
        if (clear)        count_d = '0;
        else if (do_push) count_d = count_q + CW'(1);
        else if (do_pop)  count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    // Contents need no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[count_q[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/program_sequencer.sv
// program_sequencer
// Instruction-address generator for the fetch stage: sequential increment,
// absolute jump, PC-relative branch and call/return through a return stack.
//   clk   : rising-edge clock
//   reset : async active-high reset
//   bus   : program_sequencer_if.slave (requests in, PC and stack status out)
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int              ADDR_W    = ADDR_W_DEF,
    parameter int              OFS_W     = 8,
    parameter int              RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF)
) (
    input  logic                clk,
    input  logic                reset,
    program_sequencer_if.slave  bus
);
    localparam int CW = cnt_w(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic [ADDR_W-1:0] pc_inc, ofs_ext, top_data;
    logic [CW-1:0]     count;
    logic              full, empty;
    logic              push, pop, clear;
    flow_e             flow;

    assign pc_inc  = pc_q + ADDR_W'(1);
    assign ofs_ext = ADDR_W'($signed(bus.branch_ofs));

    always_comb begin
        if (bus.ret_en)         flow = RET;
        else if (bus.call_en)   flow = CALL;
        else if (bus.jump_en)   flow = JUMP;
        else if (bus.branch_en) flow = BRANCH;
        else if (bus.hlt)       flow = HOLD;
        else                    flow = SEQ;
    end

    always_comb begin
        pc_d  = pc_q;
        ovf_d = ovf_q;
        udf_d = udf_q;
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
        case (flow)
            RET: begin
                if (!empty) begin
                    pc_d = top_data;
                    pop  = 1'b1;
                end else begin
                    // Failed return degrades to the idle behaviour.
                    pc_d  = bus.hlt ? pc_q : pc_inc;
                    udf_d = 1'b1;
                end
            end
            CALL: begin
                pc_d = bus.target_addr;
                if (!full) push  = 1'b1;
                else       ovf_d = 1'b1;
            end
            JUMP:    pc_d = bus.target_addr;
            BRANCH:  pc_d = pc_q + ofs_ext;
            HOLD:    pc_d = pc_q;
            default: pc_d = pc_inc;
        endcase
        if (bus.stall) begin
            pc_d  = pc_q;
            ovf_d = ovf_q;
            udf_d = udf_q;
            push  = 1'b0;
            pop   = 1'b0;
        end
        if (!bus.start) begin
            pc_d  = RESET_VEC;
            ovf_d = 1'b0;
            udf_d = 1'b0;
            push  = 1'b0;
            pop   = 1'b0;
            clear = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_VEC;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    pc_return_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (top_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign bus.instr_mem_addr = pc_q;
    assign bus.ras_count      = count;
    assign bus.ras_full       = full;
    assign bus.ras_empty      = empty;
    assign bus.ras_ovf        = ovf_q;
    assign bus.ras_udf        = udf_q;

endmodule
